// File: rtl/iter_squarer.sv
// ---------------------------------------------------------------------------
// iter_squarer
//   Sequential unsigned squarer built on a shift-add datapath. It consumes
//   STEP multiplier bits per busy cycle, so a WIDTH-bit square takes
//   WIDTH/STEP cycles. Its handshake matches the integer square-root unit.
//
// Parameters
//   WIDTH  operand width in bits. The result is 2*WIDTH bits.
//   STEP   multiplier bits consumed per cycle (1, 2 or 4). It must divide WIDTH.
//
// Ports
//   clock   rising-edge clock
//   reset   asynchronous, active-high reset
//   start   request; accepted in IDLE or DONE
//   value   operand, captured on the accepting edge
//   busy    high while a computation is running
//   done    high while result holds a valid square
//   result  value*value. The previous result stays visible while busy.
//
// Optional build macro
//   ISQ_EARLY_EXIT_EN  finishes as soon as the remaining multiplier bits are
//                      all zero. The results are identical; only the latency
//                      changes.
// ---------------------------------------------------------------------------
module iter_squarer #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   value,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int NCHUNK = WIDTH / STEP;
  localparam int CW     = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  // mcand is kept pre-shifted by the number of bits consumed so far. The
  // partial product therefore needs no variable shifter.
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplier_shr;
  logic               last_chunk;

  always_comb begin
    partial    = mcand_q * {{(2*WIDTH-STEP){1'b0}}, mplier_q[STEP-1:0]};
    acc_sum    = acc_q + partial;
    mplier_shr = mplier_q >> STEP;
`ifdef ISQ_EARLY_EXIT_EN
    // Once no multiplier bits remain, every later chunk would add zero.
    last_chunk = (cnt_q == CW'(1)) || (mplier_shr == '0);
`else
    last_chunk = (cnt_q == CW'(1));
`endif
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, value};
          mplier_d = value;
          acc_d    = '0;
          cnt_d    = CW'(NCHUNK);
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << STEP;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q - CW'(1);
        if (last_chunk) begin
          result_d = acc_sum;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q == S_BUSY);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_iter_squarer.sv
// ---------------------------------------------------------------------------
// tb_iter_squarer
//   Scoreboard bench for iter_squarer. It uses two instances: WIDTH=32 with
//   STEP=1, and WIDTH=32 with STEP=4. Every accepted request pushes the
//   expected square and latency into the queue for its instance. A monitor
//   pops an entry whenever an instance completes. Directed checks cover the
//   reset, hold, ignored-start, abort and back-to-back behaviour.
// ---------------------------------------------------------------------------
module tb_iter_squarer;

  typedef struct {
    logic [63:0] sq;
    int          lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [31:0] value0 = '0, value1 = '0;
  logic        busy0, done0, busy1, done1;
  logic [63:0] result0, result1;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   bcnt[2];
  logic pbusy[2];

  iter_squarer #(.WIDTH(32), .STEP(1)) u_s1 (
    .clock(clock), .reset(reset), .start(start0), .value(value0),
    .busy(busy0), .done(done0), .result(result0)
  );

  iter_squarer #(.WIDTH(32), .STEP(4)) u_s4 (
    .clock(clock), .reset(reset), .start(start1), .value(value1),
    .busy(busy1), .done(done1), .result(result1)
  );

  always #5 clock = ~clock;

  // Reference latency, computed directly from the operand.
  function automatic int exp_lat(input logic [31:0] v, input int step);
`ifdef ISQ_EARLY_EXIT_EN
    int hb;
    hb = -1;
    for (int i = 0; i < 32; i++) if (v[i]) hb = i;
    if (hb < 0) return 1;
    return (hb + step) / step;
`else
    return 32 / step;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: a completion is done rising directly after a busy cycle.
  always @(negedge clock) begin
    logic        b, d;
    logic [63:0] r;
    exp_t        e;
    int          qs;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        bcnt[i]  = 0;
        pbusy[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (i == 0) begin b = busy0; d = done0; r = result0; qs = q0.size(); end
        else        begin b = busy1; d = done1; r = result1; qs = q1.size(); end
        if (b) bcnt[i]++;
        if (d && pbusy[i]) begin
          if (qs == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done inst=%0d actual=%h required=none", i, r);
          end else begin
            if (i == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("result_inst%0d", i), r, e.sq);
            chk($sformatf("latency_inst%0d", i), 64'(bcnt[i]), 64'(e.lat));
          end
          bcnt[i] = 0;
        end
        pbusy[i] = b;
      end
    end
  end

  task automatic issue(input int i, input logic [31:0] v);
    exp_t e;
    e.sq  = 64'(v) * 64'(v);
    e.lat = exp_lat(v, (i == 0) ? 1 : 4);
    @(negedge clock);
    if (i == 0) begin start0 = 1'b1; value0 = v; q0.push_back(e); end
    else        begin start1 = 1'b1; value1 = v; q1.push_back(e); end
    @(negedge clock);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("drain_timeout", 64'(q0.size() + q1.size()), 64'd0);
  endtask

  initial begin
    exp_t        e;
    int          n;
    logic [31:0] v;

    // Reset state
    #12;
    chk("rst_busy0", 64'(busy0), 64'd0);
    chk("rst_done0", 64'(done0), 64'd0);
    chk("rst_result0", result0, 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    chk("rst_done1", 64'(done1), 64'd0);
    chk("rst_result1", result1, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // All-ones operand, then check that DONE holds its result
    issue(0, 32'hFFFF_FFFF);
    drain();
    repeat (5) @(negedge clock);
    chk("hold_done", 64'(done0), 64'd1);
    chk("hold_result", result0, 64'hFFFF_FFFE_0000_0001);

    // The same operand on both STEP values
    issue(0, 32'd12345);
    issue(1, 32'd12345);
    drain();

    // start while busy is ignored; the stale result stays visible
    issue(0, 32'd1000);
    repeat (4) @(negedge clock);
    chk("busy_mid", 64'(busy0), 64'd1);
    chk("done_mid", 64'(done0), 64'd0);
    chk("stale_result", result0, 64'd152399025);
    start0 = 1'b1;
    value0 = 32'd7;
    @(negedge clock);
    start0 = 1'b0;
    drain();

    // Reset in the middle of an operation
    issue(0, 32'h0001_0000);
    repeat (13) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_done", 64'(done0), 64'd0);
    chk("abort_result", result0, 64'd0);
    chk("abort_result_s4", result1, 64'd0);
    q0.delete();
    q1.delete();
    @(negedge clock);
    #1 reset = 1'b0;
    issue(0, 32'd5);
    drain();

    // Back-to-back operation with start held high across DONE
    @(negedge clock);
    start0 = 1'b1;
    value0 = 32'd2;
    e.sq = 64'd4;
    e.lat = exp_lat(32'd2, 1);
    q0.push_back(e);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done0 && n < 100);
    chk("b2b_first_done", 64'(done0), 64'd1);
    value0 = 32'd3;
    e.sq = 64'd9;
    e.lat = exp_lat(32'd3, 1);
    q0.push_back(e);
    @(negedge clock);
    chk("b2b_no_bubble_busy", 64'(busy0), 64'd1);
    chk("b2b_no_bubble_done", 64'(done0), 64'd0);
    start0 = 1'b0;
    drain();

    // Latency edge cases for the early-exit build, on both STEP values
    issue(0, 32'd0);
    issue(1, 32'd0);
    drain();
    issue(0, 32'd3);
    issue(1, 32'd3);
    drain();
    issue(0, 32'h8000_0000);
    issue(1, 32'h8000_0000);
    drain();

    // Random operands with assorted magnitudes
    for (int k = 0; k < 10; k++) begin
      v = $urandom >> $urandom_range(0, 31);
      issue(0, v);
      v = $urandom >> $urandom_range(0, 31);
      issue(1, v);
      drain();
    end

    repeat (3) @(negedge clock);
    chk("queues_empty", 64'(q0.size() + q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
